// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a 16-bit level toward a commanded target at a fixed tick rate
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_target command handshake;
// level = current ramped level; busy = ramp in progress; done = one-cycle completion pulse;
// pwm_out = registered PWM of level, present only when PWM_OUT_EN is defined.
// Optional feature macro: PWM_OUT_EN
module pwm_ramp_ctrl #(
    parameter int STEP_DIV = 1000,
    parameter int STEP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_target,
    output logic [15:0] level,
    output logic        busy,
    output logic        done
`ifdef PWM_OUT_EN
    ,
    output logic        pwm_out
`endif
);
    localparam logic [15:0] DIV_M1 = 16'(STEP_DIV - 1);
    localparam logic [15:0] STEP16 = 16'(STEP);
    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] target, cnt, level_nx;
    logic [16:0] diff;
    logic accept, tick, up;
    // Distance is taken at 17 bits so a full-range move never wraps; a final
    // partial step snaps to target to avoid overshoot.
    always_comb begin
        cmd_ready = state == IDLE && !rst;
        busy = state == RAMP;
        done = state == DONE;
        accept = cmd_valid && cmd_ready;
        tick = state == RAMP && cnt == DIV_M1;
        up = target > level;
        diff = up ? {1'b0, target} - {1'b0, level} : {1'b0, level} - {1'b0, target};
        level_nx = diff <= {1'b0, STEP16} ? target : up ? level + STEP16 : level - STEP16;
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = cmd_target == level ? DONE : RAMP;
            RAMP: if (tick && level_nx == target) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            level <= '0;
            target <= '0;
            cnt <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                target <= cmd_target;
                cnt <= '0;
            end else if (state == RAMP) begin
                cnt <= tick ? '0 : cnt + 16'd1;
            end
            if (tick) level <= level_nx;
        end
    end
`ifdef PWM_OUT_EN
    logic [15:0] pwm_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 16'd1;
            pwm_out <= pwm_cnt < level;
        end
    end
`endif
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed and randomized checks of pwm_ramp_ctrl against a closed-form ramp model
module tb_pwm_ramp_ctrl;
    localparam int DIVS[3]  = '{4, 3, 2};
    localparam int STEPS[3] = '{1, 5, 40000};
    logic clk = 1'b0;
    logic rst[3];
    logic cmd_valid[3];
    logic cmd_ready[3];
    logic [15:0] cmd_target[3];
    logic [15:0] level[3];
    logic busy[3];
    logic done[3];
`ifdef PWM_OUT_EN
    logic pwm_out[3];
`endif
    int checks = 0;
    int errors = 0;
    int mlev[3];
    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.STEP_DIV(4), .STEP(1)) dut_a (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_target(cmd_target[0]), .level(level[0]), .busy(busy[0]), .done(done[0])
`ifdef PWM_OUT_EN
        , .pwm_out(pwm_out[0])
`endif
    );
    pwm_ramp_ctrl #(.STEP_DIV(3), .STEP(5)) dut_b (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_target(cmd_target[1]), .level(level[1]), .busy(busy[1]), .done(done[1])
`ifdef PWM_OUT_EN
        , .pwm_out(pwm_out[1])
`endif
    );
    pwm_ramp_ctrl #(.STEP_DIV(2), .STEP(40000)) dut_c (
        .clk(clk), .rst(rst[2]), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_target(cmd_target[2]), .level(level[2]), .busy(busy[2]), .done(done[2])
`ifdef PWM_OUT_EN
        , .pwm_out(pwm_out[2])
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Closed-form expectation: j cycles after acceptance the level has moved
    // min(floor(j/DIV)*STEP, distance) toward target; the ramp lasts
    // ceil(distance/STEP)*DIV cycles, then done for one cycle, then idle.
    task automatic run_cmd(input int i, input logic [15:0] tgt, input bit hold, input logic [15:0] nxt);
        int l = mlev[i];
        int t = int'(tgt);
        int st = STEPS[i];
        int dv = DIVS[i];
        int d = t >= l ? t - l : l - t;
        int e = ((d + st - 1) / st) * dv;
        int mv;
        cmd_valid[i] = 1'b1;
        cmd_target[i] = tgt;
        for (int j = 0; j <= e + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                if (hold) cmd_target[i] = nxt;
                else cmd_valid[i] = 1'b0;
            end
            mv = (j / dv) * st;
            if (mv > d) mv = d;
            chk($sformatf("level%0d_j%0d", i, j), 32'(level[i]), 32'(t >= l ? l + mv : l - mv));
            chk($sformatf("busy%0d_j%0d", i, j), 32'(busy[i]), 32'(j < e));
            chk($sformatf("done%0d_j%0d", i, j), 32'(done[i]), 32'(j == e));
            chk($sformatf("ready%0d_j%0d", i, j), 32'(cmd_ready[i]), 32'(j > e));
        end
        mlev[i] = t;
    endtask

    function automatic logic [15:0] near(input int c, input int r);
        int lo = c - r < 0 ? 0 : c - r;
        int hi = c + r > 65535 ? 65535 : c + r;
        return 16'($urandom_range(hi, lo));
    endfunction

    task automatic rand_run(input int i, input int r, input int n);
        logic [15:0] t, t2;
        bit h;
        t = near(mlev[i], r);
        for (int k = 0; k < n; k++) begin
            t2 = near(int'(t), r);
            h = k < n - 1 ? 1'($urandom_range(0, 1)) : 1'b0;
            run_cmd(i, t, h, t2);
            t = h ? t2 : near(int'(t), r);
        end
    endtask

    initial begin
        int cnt;
        bit hit;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            cmd_valid[i] = 1'b0;
            cmd_target[i] = '0;
            mlev[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_level%0d", i), 32'(level[i]), 0);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst_done%0d", i), 32'(done[i]), 0);
            chk($sformatf("rst_ready%0d", i), 32'(cmd_ready[i]), 0);
            rst[i] = 1'b0;
        end
        #1;
        for (int i = 0; i < 3; i++) chk($sformatf("rel_ready%0d", i), 32'(cmd_ready[i]), 1);
        run_cmd(0, 16'd3, 1'b0, 16'd0);
        run_cmd(0, 16'd3, 1'b0, 16'd0);
        run_cmd(1, 16'd12, 1'b0, 16'd0);
        run_cmd(1, 16'd0, 1'b0, 16'd0);
        run_cmd(1, 16'd30, 1'b1, 16'd100);
        run_cmd(1, 16'd100, 1'b0, 16'd0);
        run_cmd(2, 16'hFFFF, 1'b0, 16'd0);
        run_cmd(2, 16'hFFFD, 1'b0, 16'd0);
        run_cmd(2, 16'd0, 1'b1, 16'd2);
        run_cmd(2, 16'd2, 1'b0, 16'd0);
        rand_run(0, 10, 8);
        rand_run(1, 60, 10);
        rand_run(2, 65535, 15);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        mlev[0] = 0;
        cmd_valid[0] = 1'b1;
        cmd_target[0] = 16'd20;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            cmd_valid[0] = 1'b0;
            hit = level[0] == 16'd5;
        end
        chk("mid_reach5", 32'(level[0]), 5);
        rst[0] = 1'b1;
        @(negedge clk);
        chk("mid_rst_level", 32'(level[0]), 0);
        chk("mid_rst_busy", 32'(busy[0]), 0);
        chk("mid_rst_done", 32'(done[0]), 0);
        chk("mid_rst_ready", 32'(cmd_ready[0]), 0);
        @(negedge clk);
        chk("mid_rst_done2", 32'(done[0]), 0);
        rst[0] = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(cmd_ready[0]), 1);
        run_cmd(0, 16'd2, 1'b0, 16'd0);
`ifdef PWM_OUT_EN
        run_cmd(2, 16'h8000, 1'b0, 16'd0);
        cnt = 0;
        for (int k = 0; k < 65536; k++) begin
            @(negedge clk);
            cnt += int'(pwm_out[2]);
        end
        chk("pwm_half", 32'(cnt), 32768);
        run_cmd(2, 16'd0, 1'b0, 16'd0);
        cnt = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            cnt += int'(pwm_out[2]);
        end
        chk("pwm_zero", 32'(cnt), 0);
`else
        cnt = 0;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
